// File: rtl/spi_master_pkg.sv
// rtl/spi_master_pkg.sv - shared types and sizing helpers for the SPI master
package spi_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_DONE
    } state_t;

    localparam int DefaultDataWidth = 8;

    function automatic int edges_per_byte(input int data_width);
        return 2 * data_width;
    endfunction

    // Counter must hold the value reached after the final edge of a byte.
    function automatic int edge_cnt_width(input int data_width);
        return $clog2(2 * data_width + 1);
    endfunction

    localparam int EdgesPerByte = edges_per_byte(DefaultDataWidth);
    localparam int EdgeCntWidth = edge_cnt_width(DefaultDataWidth);

endpackage

// File: rtl/spi_fifo.sv
// rtl/spi_fifo.sv - synchronous first-word-fall-through FIFO with concurrent push/pop
module spi_fifo #(
    parameter int DataWidth     = 8,
    parameter int FIFODepthLog2 = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [DataWidth-1:0] wdata,
    input  logic                 pop,
    output logic [DataWidth-1:0] rdata,
    output logic                 full,
    output logic                 empty
);

    localparam int Depth = 1 << FIFODepthLog2;
    localparam logic [FIFODepthLog2:0] DepthCount = (FIFODepthLog2 + 1)'(Depth);

    logic [DataWidth-1:0]     mem [Depth];
    logic [FIFODepthLog2-1:0] wr_ptr;
    logic [FIFODepthLog2-1:0] rd_ptr;
    logic [FIFODepthLog2:0]   count;
    logic                     do_push;
    logic                     do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DepthCount);
    assign do_pop  = pop && !empty;
    // A slot freed by a same-cycle pop lets a push into a full FIFO through.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spi_master_fifo.sv
// rtl/spi_master_fifo.sv - byte-wide SPI master with TX and RX FIFOs
module spi_master_fifo
    import spi_master_pkg::*;
#(
    parameter int DataWidth     = 8,
    parameter int FIFODepthLog2 = 2,
    parameter int SPPRWidth     = 4,
    parameter int SPRWidth      = 4
) (
    input  logic                 Clk_i,
    input  logic                 Reset_i,
    input  logic                 CPOL_i,
    input  logic                 CPHA_i,
    input  logic                 LSBFE_i,
    input  logic [SPPRWidth-1:0] SPPR_i,
    input  logic [SPRWidth-1:0]  SPR_i,
    input  logic                 Write_i,
    input  logic [DataWidth-1:0] Data_i,
    input  logic                 ReadNext_i,
    output logic [DataWidth-1:0] Data_o,
    output logic                 FIFOFull_o,
    output logic                 FIFOEmpty_o,
    output logic                 Transmission_o,
    output logic                 SCK_o,
    output logic                 MOSI_o,
    input  logic                 MISO_i
);

    localparam int ByteEdges = edges_per_byte(DataWidth);
    localparam int CntWidth  = edge_cnt_width(DataWidth);
    localparam int DivWidth  = SPPRWidth + (1 << SPRWidth) - 1;
    localparam logic [CntWidth-1:0] LastEdge = CntWidth'(ByteEdges - 1);

    state_t               state_q;
    state_t               state_d;
    logic                 load;
    logic                 tx_pop;
    logic                 rx_push;
    logic [DataWidth-1:0] tx_head;
    logic                 tx_full;
    logic                 tx_empty;
    logic                 rx_full;
    logic                 rx_empty;
    logic [DataWidth-1:0] rx_head;

    logic [DataWidth-1:0] shift_q;
    logic [DataWidth-1:0] rx_q;
    logic                 mosi_q;
    logic                 sck_q;
    logic                 cpha_q;
    logic                 lsbfe_q;
    logic [DivWidth-1:0]  div_reload_q;
    logic [DivWidth-1:0]  div_cnt_q;
    logic [CntWidth-1:0]  edge_cnt_q;
    logic [DivWidth:0]    half_period;
    logic [DivWidth-1:0]  half_m1;
    logic                 sck_tick;
    logic                 sample_edge;
    logic                 shift_edge;

    always_comb begin
        half_period = (DivWidth + 1)'(SPPR_i) + (DivWidth + 1)'(1);
        half_period = half_period << SPR_i;
    end
    assign half_m1 = DivWidth'(half_period - (DivWidth + 1)'(1));

    // edge_cnt_q holds completed edges, so bit 0 clear means the upcoming edge is odd.
    assign sck_tick    = (state_q == ST_XFER) && (div_cnt_q == '0);
    assign sample_edge = (edge_cnt_q[0] == cpha_q);
    assign shift_edge  = !sample_edge && (edge_cnt_q != '0) && (edge_cnt_q != LastEdge);

    spi_fifo #(
        .DataWidth     (DataWidth),
        .FIFODepthLog2 (FIFODepthLog2)
    ) u_tx_fifo (
        .clk   (Clk_i),
        .rst   (Reset_i),
        .push  (Write_i),
        .wdata (Data_i),
        .pop   (tx_pop),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    spi_fifo #(
        .DataWidth     (DataWidth),
        .FIFODepthLog2 (FIFODepthLog2)
    ) u_rx_fifo (
        .clk   (Clk_i),
        .rst   (Reset_i),
        .push  (rx_push),
        .wdata (rx_q),
        .pop   (ReadNext_i),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        tx_pop  = 1'b0;
        rx_push = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!tx_empty) begin
                    tx_pop  = 1'b1;
                    load    = 1'b1;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (sck_tick && (edge_cnt_q == LastEdge)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // A full RX FIFO discards the byte unless a read frees a slot now.
                rx_push = !rx_full || ReadNext_i;
                if (!tx_empty) begin
                    tx_pop  = 1'b1;
                    load    = 1'b1;
                    state_d = ST_XFER;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            shift_q      <= '0;
            rx_q         <= '0;
            mosi_q       <= 1'b0;
            sck_q        <= 1'b0;
            cpha_q       <= 1'b0;
            lsbfe_q      <= 1'b0;
            div_reload_q <= '0;
            div_cnt_q    <= '0;
            edge_cnt_q   <= '0;
        end else if (load) begin
            shift_q      <= tx_head;
            mosi_q       <= LSBFE_i ? tx_head[0] : tx_head[DataWidth-1];
            sck_q        <= CPOL_i;
            cpha_q       <= CPHA_i;
            lsbfe_q      <= LSBFE_i;
            div_reload_q <= half_m1;
            div_cnt_q    <= half_m1;
            edge_cnt_q   <= '0;
        end else if (state_q == ST_XFER) begin
            if (sck_tick) begin
                div_cnt_q  <= div_reload_q;
                sck_q      <= ~sck_q;
                edge_cnt_q <= edge_cnt_q + 1'b1;
                if (sample_edge) begin
                    rx_q <= lsbfe_q ? {MISO_i, rx_q[DataWidth-1:1]}
                                    : {rx_q[DataWidth-2:0], MISO_i};
                end
                if (shift_edge) begin
                    shift_q <= lsbfe_q ? (shift_q >> 1) : (shift_q << 1);
                    mosi_q  <= lsbfe_q ? shift_q[1] : shift_q[DataWidth-2];
                end
            end else begin
                div_cnt_q <= div_cnt_q - 1'b1;
            end
        end
    end

    assign SCK_o          = (state_q == ST_IDLE) ? CPOL_i : sck_q;
    assign Transmission_o = (state_q != ST_IDLE);
    assign MOSI_o         = mosi_q;
    assign FIFOFull_o     = tx_full;
    assign FIFOEmpty_o    = rx_empty;
    assign Data_o         = rx_head;

endmodule

// File: tb/tb_spi_master_fifo.sv
// tb/tb_spi_master_fifo.sv - self-checking bench for spi_master_fifo with an SPI slave model
module tb_spi_master_fifo;

    logic       Clk_i = 1'b0;
    logic       Reset_i = 1'b1;
    logic       CPOL_i, CPHA_i, LSBFE_i;
    logic [3:0] SPPR_i, SPR_i;
    logic       Write_i, ReadNext_i;
    logic [7:0] Data_i, Data_o;
    logic       FIFOFull_o, FIFOEmpty_o, Transmission_o, SCK_o, MOSI_o, MISO_i;

    logic       loop_en = 1'b0;
    logic       slave_bit = 1'b0;
    int         checks = 0;
    int         failures = 0;

    // Slave model state (owned by the monitor process)
    int         edge_n = 0, gap = 0, exp_h = 1, gap_err = 0, edges_total = 0, slave_idx = 0;
    logic       sck_prev = 1'b0, trans_prev = 1'b0, done_prev = 1'b0, fin = 1'b0;
    logic       m_cpha = 1'b0, m_lsbfe = 1'b0;
    logic [7:0] cap = 8'h00;
    logic [7:0] mosi_log [256];
    logic [7:0] slave_mem [256];

    // Stimulus / expectation state (owned by the initial block)
    logic [7:0] tx_buf [16];
    logic [7:0] rx_exp [16];

    assign MISO_i = loop_en ? MOSI_o : slave_bit;

    always #5 Clk_i = ~Clk_i;

    spi_master_fifo dut (
        .Clk_i          (Clk_i),
        .Reset_i        (Reset_i),
        .CPOL_i         (CPOL_i),
        .CPHA_i         (CPHA_i),
        .LSBFE_i        (LSBFE_i),
        .SPPR_i         (SPPR_i),
        .SPR_i          (SPR_i),
        .Write_i        (Write_i),
        .Data_i         (Data_i),
        .ReadNext_i     (ReadNext_i),
        .Data_o         (Data_o),
        .FIFOFull_o     (FIFOFull_o),
        .FIFOEmpty_o    (FIFOEmpty_o),
        .Transmission_o (Transmission_o),
        .SCK_o          (SCK_o),
        .MOSI_o         (MOSI_o),
        .MISO_i         (MISO_i)
    );

    function automatic logic pick_bit(input int idx);
        logic [7:0] b;
        b = slave_mem[slave_idx];
        return m_lsbfe ? b[idx] : b[7-idx];
    endfunction

    // SPI slave: counts SCK edges per byte, checks the half period, samples MOSI and drives MISO
    always @(negedge Clk_i) begin
        fin = 1'b0;
        if (Reset_i) begin
            edge_n = 0;
            gap = 0;
            slave_bit = 1'b0;
        end else if (Transmission_o && (!trans_prev || done_prev)) begin
            m_cpha = CPHA_i;
            m_lsbfe = LSBFE_i;
            exp_h = (int'(SPPR_i) + 1) << SPR_i;
            edge_n = 0;
            gap = 0;
            cap = 8'h00;
            slave_bit = pick_bit(0);
        end else if (Transmission_o) begin
            gap++;
            if (SCK_o !== sck_prev) begin
                edge_n++;
                edges_total++;
                if (gap != exp_h) gap_err++;
                gap = 0;
                if ((edge_n % 2 == 0) == m_cpha) begin
                    if (m_lsbfe) cap[(edge_n-1)/2] = MOSI_o;
                    else cap[7-(edge_n-1)/2] = MOSI_o;
                end else if (edge_n < 16) begin
                    slave_bit = pick_bit(edge_n / 2);
                end
                if (edge_n == 16) begin
                    mosi_log[slave_idx] = cap;
                    slave_idx++;
                    edge_n = 0;
                    fin = 1'b1;
                end
            end
        end
        done_prev = fin;
        trans_prev = Transmission_o && !Reset_i;
        sck_prev = SCK_o;
    end

    task automatic tick();
        @(negedge Clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_mode(input logic cpol, input logic cpha, input logic lsbfe,
                            input logic [3:0] sppr, input logic [3:0] spr);
        CPOL_i = cpol; CPHA_i = cpha; LSBFE_i = lsbfe; SPPR_i = sppr; SPR_i = spr;
    endtask

    task automatic fill_exp(input int n, input int base);
        for (int i = 0; i < n; i++) rx_exp[i] = loop_en ? tx_buf[i] : slave_mem[base + i];
    endtask

    task automatic wait_low(output int hi);
        hi = 0;
        for (int i = 0; i < 20000 && Transmission_o; i++) begin
            hi++;
            tick();
        end
        check("wait_low_bound", Transmission_o, 0);
    endtask

    task automatic run_bytes(input int n, input bit mid, output int hi, output int rises);
        logic prev;
        bit   done;
        hi = 0; rises = 0; prev = Transmission_o; done = 0;
        for (int c = 0; c < 30000 && !done; c++) begin
            Write_i = (c < n);
            if (c < n) Data_i = tx_buf[c];
            if (mid && c == n + 4) begin
                SPPR_i = SPPR_i + 4'd3; CPHA_i = ~CPHA_i; LSBFE_i = ~LSBFE_i;
            end
            tick();
            if (Transmission_o) hi++;
            if (Transmission_o && !prev) rises++;
            if (c >= n && prev && !Transmission_o) done = 1;
            prev = Transmission_o;
        end
        Write_i = 1'b0;
        check("run_bound", done, 1);
    endtask

    task automatic verify(input string t, input int n_sent, input int n_rx,
                          input int base, input int e0, input int g0);
        check({t, "_edges"}, edges_total - e0, 16 * n_sent);
        check({t, "_halfper"}, gap_err - g0, 0);
        for (int i = 0; i < n_sent; i++)
            check($sformatf("%s_mosi%0d", t, i), mosi_log[base + i], tx_buf[i]);
        for (int i = 0; i < n_rx; i++) begin
            check($sformatf("%s_nempty%0d", t, i), FIFOEmpty_o, 0);
            check($sformatf("%s_rx%0d", t, i), Data_o, rx_exp[i]);
            ReadNext_i = 1'b1;
            tick();
            ReadNext_i = 1'b0;
        end
        check({t, "_drained"}, FIFOEmpty_o, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int hi, rises, base, e0, g0, n, h;
        set_mode(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        Write_i = 1'b0; ReadNext_i = 1'b0; Data_i = 8'h00;
        for (int i = 0; i < 256; i++) slave_mem[i] = 8'($urandom);
        tick(); tick();

        check("rst_empty", FIFOEmpty_o, 1);
        check("rst_full", FIFOFull_o, 0);
        check("rst_data", Data_o, 0);
        check("rst_trans", Transmission_o, 0);
        check("rst_mosi", MOSI_o, 0);
        check("rst_sck", SCK_o, 1);
        CPOL_i = 1'b0;
        #1 check("idle_sck_live", SCK_o, 0);
        Reset_i = 1'b0;
        tick();

        // Mode 3, loopback, H=1, explicit latency
        set_mode(1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
        loop_en = 1'b1;
        tick();
        check("m3_sck_idle", SCK_o, 1);
        base = slave_idx; e0 = edges_total; g0 = gap_err;
        tx_buf[0] = 8'h50; fill_exp(1, base);
        Write_i = 1'b1; Data_i = 8'h50;
        tick();
        check("lat_n1_trans", Transmission_o, 0);
        Write_i = 1'b0;
        tick();
        check("lat_n2_trans", Transmission_o, 1);
        check("lat_n2_mosi", MOSI_o, 0);
        check("lat_n2_sck", SCK_o, 1);
        wait_low(hi);
        check("m3_trans_len", hi, 17);
        verify("m3", 1, 1, base, e0, g0);

        // Mode 0, LSB first, slave returns 0xA3
        set_mode(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
        loop_en = 1'b0;
        base = slave_idx; e0 = edges_total; g0 = gap_err;
        slave_mem[base] = 8'hA3;
        tx_buf[0] = 8'h01; fill_exp(1, base);
        run_bytes(1, 0, hi, rises);
        check("m0_trans_len", hi, 17);
        verify("m0", 1, 1, base, e0, g0);

        // H=6, with mode/baud disturbed mid-byte
        set_mode(1'($urandom), 1'($urandom), 1'($urandom), 4'd2, 4'd1);
        loop_en = 1'($urandom);
        base = slave_idx; e0 = edges_total; g0 = gap_err;
        tx_buf[0] = 8'($urandom); fill_exp(1, base);
        run_bytes(1, 1, hi, rises);
        check("h6_trans_len", hi, 97);
        verify("h6", 1, 1, base, e0, g0);

        // Back-to-back bytes
        set_mode(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        loop_en = 1'b1;
        base = slave_idx; e0 = edges_total; g0 = gap_err;
        tx_buf[0] = 8'h11; tx_buf[1] = 8'h22; tx_buf[2] = 8'h33; fill_exp(3, base);
        run_bytes(3, 0, hi, rises);
        check("b2b_trans_len", hi, 51);
        check("b2b_rises", rises, 1);
        verify("b2b", 3, 3, base, e0, g0);

        // Randomized modes, baud and burst lengths
        for (int it = 0; it < 6; it++) begin
            set_mode(1'($urandom), 1'($urandom), 1'($urandom),
                     4'($urandom_range(0, 3)), 4'($urandom_range(0, 2)));
            loop_en = 1'($urandom);
            n = $urandom_range(1, 3);
            h = (int'(SPPR_i) + 1) << SPR_i;
            base = slave_idx; e0 = edges_total; g0 = gap_err;
            for (int i = 0; i < n; i++) tx_buf[i] = 8'($urandom);
            fill_exp(n, base);
            run_bytes(n, 0, hi, rises);
            check($sformatf("rnd%0d_trans_len", it), hi, n * (16 * h + 1));
            check($sformatf("rnd%0d_rises", it), rises, 1);
            verify($sformatf("rnd%0d", it), n, n, base, e0, g0);
        end

        // Slow baud: TX FIFO fills after 5 accepted writes
        set_mode(1'b0, 1'b0, 1'b0, 4'd15, 4'd15);
        loop_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            Write_i = 1'b1; Data_i = 8'($urandom);
            tick();
            if (i == 3) check("slow_full_after4", FIFOFull_o, 0);
            if (i >= 4) check($sformatf("slow_full_after%0d", i + 1), FIFOFull_o, 1);
        end
        Write_i = 1'b0;
        check("slow_trans", Transmission_o, 1);
        Reset_i = 1'b1;
        tick();
        Reset_i = 1'b0;
        check("slow_rst_trans", Transmission_o, 0);
        check("slow_rst_full", FIFOFull_o, 0);
        check("slow_rst_empty", FIFOEmpty_o, 1);
        tick();

        // Fast burst of 6: 6th dropped at TX, 5th dropped at RX
        set_mode(1'b1, 1'b0, 1'b1, 4'd0, 4'd0);
        loop_en = 1'b1;
        base = slave_idx; e0 = edges_total; g0 = gap_err;
        for (int i = 0; i < 6; i++) tx_buf[i] = 8'($urandom);
        fill_exp(4, base);
        run_bytes(6, 0, hi, rises);
        check("ovf_trans_len", hi, 85);
        check("ovf_rises", rises, 1);
        verify("ovf", 5, 4, base, e0, g0);

        // Reset at edge 7 of a byte with a second byte queued
        set_mode(1'($urandom), 1'($urandom), 1'($urandom), 4'd1, 4'd0);
        loop_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            Write_i = 1'b1; Data_i = 8'($urandom);
            tick();
        end
        Write_i = 1'b0;
        for (int i = 0; i < 500 && edge_n != 7; i++) tick();
        check("ab_reach_edge7", edge_n, 7);
        Reset_i = 1'b1;
        #1;
        check("ab_sck", SCK_o, CPOL_i);
        check("ab_trans", Transmission_o, 0);
        tick();
        check("ab_empty", FIFOEmpty_o, 1);
        check("ab_full", FIFOFull_o, 0);
        check("ab_data", Data_o, 0);
        check("ab_mosi", MOSI_o, 0);
        Reset_i = 1'b0;
        repeat (6) tick();
        check("ab_queue_lost", Transmission_o, 0);
        base = slave_idx; e0 = edges_total; g0 = gap_err;
        tx_buf[0] = 8'($urandom); fill_exp(1, base);
        run_bytes(1, 0, hi, rises);
        check("ab_next_len", hi, 33);
        verify("ab_next", 1, 1, base, e0, g0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_master_fifo.md
Name: spi_master_fifo

Overview:
Byte-wide SPI master with transmit and receive FIFOs. It serves the sensor-readout apps on the SPI side: it consumes bytes written through SPI_Write, shifts them out on SCK/MOSI, and returns the MISO bytes through SPI_ReadNext/SPI_DataOut. Chip select is not driven here; each app drives its own CS. Mode (CPOL/CPHA/LSBFE) and baud rate come from ports.

Parameters:
DataWidth, 8, bits per transfer
FIFODepthLog2, 2, log2 of depth of each FIFO (default depth 4)
SPPRWidth, 4, width of baud pre-prescaler
SPRWidth, 4, width of baud exponent

Ports:
Clk_i  in  1  clock
Reset_i  in  1  asynchronous, active-high reset
CPOL_i  in  1  SCK idle level
CPHA_i  in  1  0: sample on leading edge; 1: sample on trailing edge
LSBFE_i  in  1  1: LSB first
SPPR_i  in  SPPRWidth  baud pre-prescaler
SPR_i  in  SPRWidth  baud exponent
Write_i  in  1  push Data_i into TX FIFO
Data_i  in  DataWidth  TX data
ReadNext_i  in  1  pop RX FIFO
Data_o  out  DataWidth  RX FIFO head (first-word fall-through)
FIFOFull_o  out  1  TX FIFO full
FIFOEmpty_o  out  1  RX FIFO empty
Transmission_o  out  1  transfer in progress
SCK_o  out  1  serial clock
MOSI_o  out  1  serial data out
MISO_i  in  1  serial data in

Behaviour:
- Reset values: FIFOs empty, FIFOEmpty_o=1, FIFOFull_o=0, Data_o=0, Transmission_o=0, MOSI_o=0, SCK_o=CPOL_i. Reset mid-byte aborts the byte immediately; FIFO contents are lost.
- Half-period H = (SPPR_i+1) * 2^SPR_i clocks. One byte = 16 SCK edges = 16*H clocks.
- FSM states:
  - Idle: SCK_o=CPOL_i. If TX FIFO is non-empty, pop it, load the shift register, latch CPOL/CPHA/LSBFE/SPPR/SPR, and go to Xfer.
  - Xfer: the divider counts H; each expiry toggles SCK. Edge k=1..16.
    - CPHA=0: odd k samples MISO, even k<16 shifts MOSI.
    - CPHA=1: even k samples MISO, odd k>1 shifts MOSI.
    - MOSI_o shows the first bit (MSB, or LSB if LSBFE) from the load cycle.
    - After edge 16, go to Done.
  - Done (1 cycle): push the received byte into the RX FIFO. If the TX FIFO is non-empty, pop it and reload straight into Xfer; otherwise go to Idle.
- Latency: Write_i high in cycle N (Idle, FIFO empty). Entry is visible at edge N+1; load happens at edge N+2, where Transmission_o=1 and MOSI_o=first bit.
- Transmission_o is 1 in Xfer and Done, so it stays high across back-to-back bytes. It falls on the edge where Done returns to Idle.
- Mode and baud changes mid-byte are ignored until the next load. The idle SCK level follows CPOL_i live.
- MOSI_o holds the last bit after a byte.
- FIFO rule, both FIFOs:
  - A push is accepted iff the FIFO is not full, or a pop occurs in the same cycle.
  - A pop on empty is ignored.
  - A push on full without a concurrent pop is dropped, with no status.
  - For TX this means Write_i while full is dropped, unless the FSM pops in that cycle.
  - For RX this means a byte completing while full is discarded, unless ReadNext_i is high in that cycle.
- Pointers wrap modulo 2^FIFODepthLog2, with a count register of FIFODepthLog2+1 bits.
- Data_o updates on the edge after a pop, or after a push into an empty FIFO.

Decomposition:
- Package spi_master_pkg: state enum (Idle, Xfer, Done), EdgesPerByte=2*DataWidth, edge-counter width constant.
- Sub-module spi_fifo (DataWidth, FIFODepthLog2): synchronous FIFO with first-word fall-through, full/empty flags and concurrent push/pop. Instantiated twice, for TX and RX.

Test Plan:
- Mode 3 (CPOL=1, CPHA=1, LSBFE=0), SPPR=0, SPR=0, MISO looped to MOSI, write 0x50 -> SCK idles 1, 16 toggles of 1 clock each, MOSI 0,1,0,1,0,0,0,0, FIFOEmpty_o falls and Data_o=0x50, Transmission_o high for 17 clocks.
- Mode 0, LSBFE=1, slave model returns 0xA3, write 0x01 -> MOSI sequence 1,0,0,0,0,0,0,0; sampled byte 0xA3; ReadNext_i then sets FIFOEmpty_o=1.
- SPPR=2, SPR=1 -> H=6 clocks; byte spans 96 clocks between load and Done.
- Write 0x11,0x22,0x33 in consecutive cycles -> Transmission_o never drops between bytes; RX returns the three loopback bytes in order.
- Write 6 bytes while SPPR=15, SPR=15 (slow) -> FIFOFull_o=1 after the 5th accepted byte (1 in shift register plus 4 in FIFO); 6th dropped. With no ReadNext, RX keeps bytes 1-4 and drops bytes 5-6.
- Assert Reset_i at edge 7 of a byte -> SCK_o returns to CPOL_i and Transmission_o=0 asynchronously; both FIFOs empty; next write transfers normally.
